lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the RISC-V core's memory stage, sitting directly upstream of the data memory. It accepts one load or store request from execute over a valid/ready handshake and checks funct3 legality and address alignment. It drives the data memory's write-enable, address, access-size and write-data inputs for exactly one cycle, then sign- or zero-extends returned load data. The result, with any fault, is presented to writeback on a second valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32: data/address width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V load/store funct3.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_rd`  in  5  destination register tag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  writeback accepts response.
- `rsp_data`  out  32  extended load data; 0 for stores and faults.
- `rsp_rd`  out  5  captured `req_rd`.
- `rsp_fault`  out  2  00 none, 01 misaligned, 10 illegal funct3.
- `rsp_badaddr`  out  32  captured address; valid when `rsp_fault` is nonzero, else 0.
- `mem_memwrite`  out  1  data-memory write enable.
- `mem_addr`  out  32  data-memory byte address.
- `mem_load_type`  out  3  data-memory size code: 000 byte, 001 half, 010 word.
- `mem_wdata`  out  32  data-memory write data.
- `mem_rdata`  in  32  data-memory combinational read data, zero-filled above access size.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE → capture all `req_*` fields when `req_valid && req_ready`.
  - No fault → go to ACCESS.
  - Fault → go to RESP.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value → fault 10.
- Alignment:
  - Half access with `addr[0]`=1 → fault 01.
  - Word access with `addr[1:0]`≠00 → fault 01.
  - Illegal funct3 takes priority over misaligned.
- A faulting request never touches memory; `mem_memwrite` stays 0.
- ACCESS lasts exactly one cycle.
  - `mem_load_type` = {0, funct3[1:0]}.
  - `mem_addr` = captured address; `mem_wdata` = captured wdata.
  - `mem_memwrite` = captured `we`.
  - For loads, `mem_rdata` is registered at the end of the cycle after extension:
    - LB: sign from bit 7.
    - LH: sign from bit 15.
    - LBU: mask to [7:0].
    - LHU: mask to [15:0].
    - LW: pass through.
  - Go to RESP.
- RESP: `rsp_valid`=1; all `rsp_*` held stable until `rsp_ready`=1, then go to IDLE.
- `mem_memwrite` is 0 in every state other than ACCESS. `mem_addr`, `mem_load_type` and `mem_wdata` show the captured values at all times.

## Timing
- All outputs are 0 during reset except `req_ready`=1, since state is IDLE. Captured fields also reset to 0.
- Load or store: accept at edge N; ACCESS in cycle N+1; `rsp_valid` from cycle N+2.
- Fault: `rsp_valid` from cycle N+1.
- Stores commit to memory on the rising edge ending ACCESS.
- Maximum throughput is one request per 3 cycles, or 2 cycles for faults. Back-pressure on `rsp_ready` extends RESP indefinitely.
- `req_ready` is a pure decode of state==IDLE, with no combinational path from `rsp_ready`.
- Asserting `resetn` low in any state returns to IDLE immediately. An in-flight store is dropped if reset is asserted before the ACCESS edge.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Fault enum `lsu_fault_e`.
  - State enum `lsu_state_e`.
- One combinational sub-module, `load_extend`:
  - Inputs: funct3 and raw read data.
  - Output: extended 32-bit data.
  - Reused by the core's future cache path.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 → one `mem_memwrite` pulse in ACCESS; load `rsp_data`=0xDEADBEEF, `rsp_fault`=00, `rsp_valid` 2 cycles after accept.
- SB 0x13 wdata 0x80; then LB 0x13 → `rsp_data`=0xFFFFFF80; LBU 0x13 → 0x00000080.
- SH 0x22 wdata 0x8001; then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- LW 0x05 → `rsp_fault`=01, `rsp_badaddr`=0x05, `mem_memwrite` never high, `rsp_valid` 1 cycle after accept.
- Store funct3 100 to 0x08 → `rsp_fault`=10, memory unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable and `req_ready`=0; then drop `resetn` mid-ACCESS on a SW → `req_ready`=1, no write, `rsp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, fault and state
// encodings, and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_FUNCT3   = 2'b10
    } lsu_fault_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Illegal funct3 wins over misalignment; funct3[1:0] encodes the access size.
    function automatic lsu_fault_e lsu_check(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic       legal;
        lsu_fault_e fault;
        if (we)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        fault = FAULT_NONE;
        if (!legal)
            fault = FAULT_FUNCT3;
        else if (funct3[1:0] == 2'b01 && addr_lo[0])
            fault = FAULT_MISALIGN;
        else if (funct3[1:0] == 2'b10 && addr_lo != 2'b00)
            fault = FAULT_MISALIGN;
        return fault;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw data-memory read data according to load funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
            F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
            F3_BU:   data = {24'h0, rdata[7:0]};
            F3_HU:   data = {16'h0, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: accepts one request, performs a single-cycle
// data-memory access, and holds the response until writeback takes it.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic [1:0]      rsp_fault,
    output logic [XLEN-1:0] rsp_badaddr,
    output logic            mem_memwrite,
    output logic [XLEN-1:0] mem_addr,
    output logic [2:0]      mem_load_type,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_reg, state_next;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [4:0]      rd_reg;
    lsu_fault_e      fault_reg;
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] ext_data;
    lsu_fault_e      req_fault;

    assign req_fault = lsu_check(req_we, req_funct3, req_addr[1:0]);

    load_extend u_load_extend (
        .funct3 (funct3_reg),
        .rdata  (mem_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:
                if (req_valid)
                    state_next = (req_fault == FAULT_NONE) ? ST_ACCESS : ST_RESP;
            ST_ACCESS:
                state_next = ST_RESP;
            ST_RESP:
                if (rsp_ready)
                    state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // data_reg is cleared on capture so stores and faults respond with zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rd_reg     <= 5'd0;
            fault_reg  <= FAULT_NONE;
            data_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE && req_valid) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                rd_reg     <= req_rd;
                fault_reg  <= req_fault;
                data_reg   <= '0;
            end
            if (state_reg == ST_ACCESS && !we_reg)
                data_reg <= ext_data;
        end
    end

    assign req_ready     = (state_reg == ST_IDLE);
    assign rsp_valid     = (state_reg == ST_RESP);
    assign rsp_data      = data_reg;
    assign rsp_rd        = rd_reg;
    assign rsp_fault     = fault_reg;
    assign rsp_badaddr   = (fault_reg != FAULT_NONE) ? addr_reg : '0;
    assign mem_memwrite  = (state_reg == ST_ACCESS) && we_reg;
    assign mem_addr      = addr_reg;
    assign mem_load_type = {1'b0, funct3_reg[1:0]};
    assign mem_wdata     = wdata_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: byte-array data memory, transaction
// level reference model, directed cases followed by randomized traffic.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_fault;
    logic [31:0] rsp_badaddr;
    logic        mem_memwrite;
    logic [31:0] mem_addr;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int write_cnt = 0;

    logic [7:0] dmem [256] = '{default: 8'h00};
    logic [7:0] mdl  [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rd       (rsp_rd),
        .rsp_fault    (rsp_fault),
        .rsp_badaddr  (rsp_badaddr),
        .mem_memwrite (mem_memwrite),
        .mem_addr     (mem_addr),
        .mem_load_type(mem_load_type),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory: synchronous write, combinational zero-filled read.
    always @(posedge clk) begin
        if (mem_memwrite) begin
            write_cnt <= write_cnt + 1;
            dmem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_load_type[1:0] != 2'b00)
                dmem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
            if (mem_load_type[1:0] == 2'b10) begin
                dmem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
                dmem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_load_type[1:0])
            2'b00: mem_rdata[7:0]  = dmem[mem_addr[7:0]];
            2'b01: mem_rdata[15:0] = {dmem[8'(mem_addr[7:0] + 8'd1)], dmem[mem_addr[7:0]]};
            2'b10: mem_rdata = {dmem[8'(mem_addr[7:0] + 8'd3)], dmem[8'(mem_addr[7:0] + 8'd2)],
                                dmem[8'(mem_addr[7:0] + 8'd1)], dmem[mem_addr[7:0]]};
            default: mem_rdata = 32'h0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: expected fault from the legality and alignment rules.
    function automatic logic [1:0] ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            return 2'b10;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if ((addr % size) != 0)
            return 2'b01;
        return 2'b00;
    endfunction

    // Reference: load value computed arithmetically from the model byte array.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        longint b0, b1, v;
        logic [7:0] a;
        a  = addr[7:0];
        b0 = longint'(mdl[a]);
        b1 = longint'(mdl[8'(a + 8'd1)]);
        case (f3)
            3'd0: v = (b0 >= 128) ? b0 - 256 : b0;
            3'd1: v = (b0 + 256 * b1 >= 32768) ? b0 + 256 * b1 - 65536 : b0 + 256 * b1;
            3'd4: v = b0;
            3'd5: v = b0 + 256 * b1;
            default: v = longint'({mdl[8'(a + 8'd3)], mdl[8'(a + 8'd2)], mdl[8'(a + 8'd1)], mdl[a]});
        endcase
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++)
            mdl[8'(addr[7:0] + 8'(i))] = wdata[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int hold);
        logic [1:0]  exp_fault;
        logic [31:0] exp_data, exp_bad;
        int          exp_lat, exp_writes, lat, wc0;
        exp_fault  = ref_fault(we, f3, addr);
        exp_data   = (exp_fault == 2'b00 && !we) ? ref_load(f3, addr) : 32'h0;
        exp_bad    = (exp_fault != 2'b00) ? addr : 32'h0;
        exp_lat    = (exp_fault != 2'b00) ? 1 : 2;
        exp_writes = (exp_fault == 2'b00 && we) ? 1 : 0;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd; rsp_ready = 1'b0;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        wc0 = write_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);

        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat == 1) begin
                check_eq("acc_memwrite", 32'(mem_memwrite), 32'(we));
                check_eq("acc_addr", mem_addr, addr);
                check_eq("acc_type", 32'(mem_load_type), {29'h0, 1'b0, f3[1:0]});
                if (we) check_eq("acc_wdata", mem_wdata, wdata);
            end
        end
        check_eq("rsp_latency", 32'(lat), 32'(exp_lat));
        check_eq("write_pulses", 32'(write_cnt - wc0), 32'(exp_writes));

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            check_eq("rsp_data", rsp_data, exp_data);
            check_eq("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
            check_eq("rsp_rd", 32'(rsp_rd), 32'(rd));
            check_eq("rsp_badaddr", rsp_badaddr, exp_bad);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check_eq("rsp_done_ready", 32'(req_ready), 32'd1);
        if (exp_writes == 1) ref_store(f3, addr, wdata);
        $display("txn we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> data=0x%08h fault=%0d lat=%0d hold=%0d",
                 we, f3, addr, wdata, rsp_data, rsp_fault, lat, hold);
    endtask

    initial begin
        int wc0;
        resetn = 1'b0;
        #23;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check_eq("rst_mem_write", 32'(mem_memwrite), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_type", 32'(mem_load_type), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5'd2, 0);
        check_eq("lw_deadbeef", ref_load(3'd2, 32'h10), 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h13, 32'h80, 5'd3, 0);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 5'd4, 0);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 5'd5, 1);
        do_req(1'b1, 3'd1, 32'h22, 32'h8001, 5'd6, 0);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, 5'd7, 0);
        do_req(1'b0, 3'd5, 32'h22, 32'h0, 5'd8, 0);
        do_req(1'b0, 3'd2, 32'h05, 32'h0, 5'd9, 0);
        do_req(1'b1, 3'd4, 32'h08, 32'hFFFFFFFF, 5'd10, 0);
        do_req(1'b0, 3'd2, 32'h08, 32'h0, 5'd11, 0);
        do_req(1'b0, 3'd1, 32'h23, 32'h0, 5'd12, 0);
        do_req(1'b0, 3'd3, 32'h23, 32'h0, 5'd13, 0);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 5'd14, 5);

        // Reset during ACCESS of a store: no write, back to IDLE immediately.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h30; req_wdata = 32'h12345678; req_rd = 5'd15;
        wc0 = write_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("rstacc_req_ready", 32'(req_ready), 32'd1);
        check_eq("rstacc_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rstacc_memwrite", 32'(mem_memwrite), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        check_eq("rstacc_no_write", 32'(write_cnt - wc0), 32'd0);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, 5'd16, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
            do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                   5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
